// File: rtl/serial_mul_if.sv
// Operand/product valid-ready bundle shared by the serial multiplier and its clients.
// The master side supplies operands and consumes the product; the slave side is the multiplier.
interface serial_mul_if #(
  parameter int width = 32
);
  logic [width-1:0]   x;
  logic [width-1:0]   y;
  logic               data_x_vld;
  logic               data_x_rdy;
  logic               data_y_vld;
  logic               data_y_rdy;
  logic [2*width-1:0] product;
  logic               d_out_vld;
  logic               d_out_rdy;

  modport master (
    output x, y, data_x_vld, data_y_vld, d_out_rdy,
    input  data_x_rdy, data_y_rdy, product, d_out_vld
  );

  modport slave (
    input  x, y, data_x_vld, data_y_vld, d_out_rdy,
    output data_x_rdy, data_y_rdy, product, d_out_vld
  );
endinterface

// File: rtl/serial_mul.sv
// Bit-serial unsigned shift-and-add multiplier: one multiplier bit per clock,
// exact 2*width-bit product returned through a valid-ready handshake.
module serial_mul #(
  parameter int width = 32
) (
  input  logic        clk,
  input  logic        syn_reset,
  serial_mul_if.slave bus
);

  localparam int cnt_w = $clog2(width) + 1;

  localparam logic [1:0] LOAD = 2'b00;
  localparam logic [1:0] COMP = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]         state;
  logic               got_x;
  logic               got_y;
  logic [cnt_w-1:0]   counter;
  logic [2*width-1:0] mcand_sh;
  logic [width-1:0]   mplier;
  logic [2*width-1:0] acc;
  logic [2*width-1:0] acc_next;
  logic [2*width-1:0] product_q;

  logic x_rdy;
  logic y_rdy;
  logic x_hs;
  logic y_hs;
  logic both_have;
  logic last_iter;

  // Handshake outputs depend on registered state only.
  assign x_rdy     = (state == LOAD) && !got_x;
  assign y_rdy     = (state == LOAD) && !got_y;
  assign x_hs      = bus.data_x_vld && x_rdy;
  assign y_hs      = bus.data_y_vld && y_rdy;
  assign both_have = (got_x || x_hs) && (got_y || y_hs);
  assign last_iter = (counter == cnt_w'(width - 1));

  assign bus.data_x_rdy = x_rdy;
  assign bus.data_y_rdy = y_rdy;
  assign bus.d_out_vld  = (state == DONE);
  assign bus.product    = product_q;

  // The multiplicand is kept pre-shifted, equivalent to adding it shifted left by counter.
  always_comb begin
    acc_next = acc + (mplier[0] ? mcand_sh : '0);
  end

  always_ff @(posedge clk) begin
    if (syn_reset) begin
      state     <= LOAD;
      got_x     <= 1'b0;
      got_y     <= 1'b0;
      counter   <= '0;
      mcand_sh  <= '0;
      mplier    <= '0;
      acc       <= '0;
      product_q <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (x_hs) mcand_sh <= {{width{1'b0}}, bus.x};
          if (y_hs) mplier <= bus.y;
          if (both_have) begin
            state   <= COMP;
            acc     <= '0;
            counter <= '0;
            got_x   <= 1'b0;
            got_y   <= 1'b0;
          end else begin
            if (x_hs) got_x <= 1'b1;
            if (y_hs) got_y <= 1'b1;
          end
        end
        COMP: begin
          acc      <= acc_next;
          mcand_sh <= mcand_sh << 1;
          mplier   <= mplier >> 1;
          counter  <= counter + cnt_w'(1);
          if (last_iter) begin
            product_q <= acc_next;
            state     <= DONE;
          end
        end
        DONE: begin
          if (bus.d_out_rdy) state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
